// File: rtl/config_write_fifo_wide.sv
// Config-bus sink: gathers CONF_W-wide config beats into DATA_W-wide elements
// and queues them for a ready/valid consumer, with soft clear and sticky overflow.

module config_write_fifo_wide_lane #(
    parameter int CONF_W = 64,
    parameter int LANE   = 0,
    parameter int BCW    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr,
    input  logic              clr,
    input  logic [BCW-1:0]    beat_cnt,
    input  logic [CONF_W-1:0] conf_data,
    output logic [CONF_W-1:0] q
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            q <= '0;
        else if (clr)
            q <= '0;
        else if (wr && beat_cnt == BCW'(LANE))
            q <= conf_data;
    end
endmodule

module config_write_fifo_wide #(
    parameter logic [31:0] ADDR   = 32'd0,
    parameter int          CONF_W = 64,
    parameter int          DATA_W = 128,
    parameter int          DEPTH  = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         conf_valid,
    input  logic [31:0]                  conf_addr,
    input  logic [CONF_W-1:0]            conf_data,
    output logic [DATA_W-1:0]            out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [$clog2(DEPTH+1)-1:0]   fill_level,
    output logic                         overflow,
    output logic [$clog2(((DATA_W+CONF_W-1)/CONF_W)+1)-1:0] beat_cnt
);
    localparam int BEATS = (DATA_W + CONF_W - 1) / CONF_W;
    localparam int BCW   = $clog2(BEATS + 1);
    localparam int FLW   = $clog2(DEPTH + 1);
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic                           data_wr, ctrl_wr, clr, last_beat;
    logic                           pop, push_ok, push_drop;
    logic [BEATS-1:0][CONF_W-1:0]   lanes;
    logic [BEATS*CONF_W-1:0]        asm_flat;
    logic [DATA_W-1:0]              elem;
    logic [PW-1:0]                  rd_ptr, wr_ptr;
    logic [DATA_W-1:0]              mem [DEPTH];

    assign data_wr   = conf_valid && (conf_addr == ADDR);
    assign ctrl_wr   = conf_valid && (conf_addr == ADDR + 32'd1);
    assign clr       = ctrl_wr && conf_data[0];
    assign last_beat = data_wr && (beat_cnt == BCW'(BEATS - 1));

    // Lanes below the top one are held; the final beat goes straight into the element.
    for (genvar k = 0; k < BEATS - 1; k++) begin : g_lane
        config_write_fifo_wide_lane #(
            .CONF_W (CONF_W),
            .LANE   (k),
            .BCW    (BCW)
        ) u_lane (
            .clk       (clk),
            .rst       (rst),
            .wr        (data_wr),
            .clr       (clr),
            .beat_cnt  (beat_cnt),
            .conf_data (conf_data),
            .q         (lanes[k])
        );
    end
    assign lanes[BEATS-1] = conf_data;
    assign asm_flat       = lanes;
    assign elem           = asm_flat[DATA_W-1:0];

    assign out_valid = (fill_level != '0);
    assign out_data  = mem[rd_ptr];
    assign pop       = out_valid && out_ready;
    assign push_ok   = last_beat && ((fill_level < FLW'(DEPTH)) || pop);
    assign push_drop = last_beat && !push_ok;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= elem;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fill_level <= '0;
            beat_cnt   <= '0;
            overflow   <= 1'b0;
        end else begin
            if (clr) begin
                // A pop handshaken this cycle is simply absorbed by the clear.
                rd_ptr     <= '0;
                wr_ptr     <= '0;
                fill_level <= '0;
                beat_cnt   <= '0;
            end else begin
                if (pop)
                    rd_ptr <= ptr_next(rd_ptr);
                if (push_ok)
                    wr_ptr <= ptr_next(wr_ptr);
                case ({push_ok, pop})
                    2'b10:   fill_level <= fill_level + 1'b1;
                    2'b01:   fill_level <= fill_level - 1'b1;
                    default: fill_level <= fill_level;
                endcase
                if (data_wr)
                    beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
            end
            if (push_drop)
                overflow <= 1'b1;
            else if (ctrl_wr && conf_data[1])
                overflow <= 1'b0;
        end
    end
endmodule

// File: tb/tb_config_write_fifo_wide.sv
// Randomised and directed bench for config_write_fifo_wide against a queue-based model.

module tb_config_write_fifo_wide;
    localparam int CONF_W = 64;
    localparam int DATA_W = 128;
    localparam int DEPTH  = 4;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               conf_valid = 1'b0;
    logic [31:0]        conf_addr = '0;
    logic [CONF_W-1:0]  conf_data = '0;
    logic [DATA_W-1:0]  out_data;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic [2:0]         fill_level;
    logic               overflow;
    logic [1:0]         beat_cnt;

    config_write_fifo_wide #(
        .ADDR   (32'd8),
        .CONF_W (CONF_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .conf_valid (conf_valid),
        .conf_addr  (conf_addr),
        .conf_data  (conf_data),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .fill_level (fill_level),
        .overflow   (overflow),
        .beat_cnt   (beat_cnt)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    // Reference model: element queue, partial beat list, sticky flag.
    logic [DATA_W-1:0] mq[$];
    logic [CONF_W-1:0] part[$];
    bit                movf;
    logic [DATA_W-1:0] got[$];
    logic [DATA_W-1:0] exp_pop[$];

    function automatic logic [CONF_W-1:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    task automatic model_reset();
        mq.delete();
        part.delete();
        movf = 1'b0;
    endtask

    // One config cycle: drive at negedge, advance the model, settle after the edge.
    task automatic step(input bit v, input logic [31:0] a, input logic [CONF_W-1:0] d, input bit r);
        bit pop, acc;
        logic [DATA_W-1:0] e;
        acc = 1'b0;
        e = '0;
        @(negedge clk);
        conf_valid = v; conf_addr = a; conf_data = d; out_ready = r;
        if (out_valid && r) got.push_back(out_data);
        pop = (mq.size() > 0) && r;
        if (pop) exp_pop.push_back(mq[0]);
        if (v && a == 32'd8) begin
            part.push_back(d);
            if (part.size() == 2) begin
                e = {part[1], part[0]};
                part.delete();
                if (mq.size() < DEPTH || pop) acc = 1'b1;
                else movf = 1'b1;
            end
        end
        if (pop) void'(mq.pop_front());
        if (acc) mq.push_back(e);
        if (v && a == 32'd9) begin
            if (d[0]) begin mq.delete(); part.delete(); end
            if (d[1]) movf = 1'b0;
        end
        @(posedge clk);
        #1;
        conf_valid = 1'b0;
    endtask

    task automatic push_elem(input logic [DATA_W-1:0] e, input bit r);
        step(1'b1, 32'd8, e[63:0], r);
        step(1'b1, 32'd8, e[127:64], r);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        model_reset();
        #2;
        n_chk++; if (fill_level !== 3'd0) begin n_fail++; $display("FAIL reset_fill: got %0d exp 0", fill_level); end
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b exp 0", out_valid); end
        n_chk++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b exp 0", overflow); end
        n_chk++; if (beat_cnt !== 2'd0) begin n_fail++; $display("FAIL reset_beat: got %0d exp 0", beat_cnt); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_assembly();
        step(1'b1, 32'd8, 64'h1111, 1'b1);
        n_chk++; if (beat_cnt !== 2'd1) begin n_fail++; $display("FAIL asm_beat1: got %0d exp 1", beat_cnt); end
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL asm_valid0: got %b exp 0", out_valid); end
        step(1'b1, 32'd8, 64'h2222, 1'b1);
        n_chk++; if (beat_cnt !== 2'd0) begin n_fail++; $display("FAIL asm_beat0: got %0d exp 0", beat_cnt); end
        n_chk++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL asm_valid1: got %b exp 1", out_valid); end
        n_chk++; if (out_data !== 128'h0000000000002222_0000000000001111) begin
            n_fail++; $display("FAIL asm_data: got %h exp 00000000000022220000000000001111", out_data);
        end
        step(1'b0, 32'd0, 64'd0, 1'b1);
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL asm_drained: got %b exp 0", out_valid); end
    endtask

    task automatic test_overflow();
        logic [DATA_W-1:0] el[5];
        got.delete();
        for (int i = 0; i < 5; i++) begin
            el[i] = {rnd64(), rnd64()};
            push_elem(el[i], 1'b0);
            if (i == 3) begin
                n_chk++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_early: got %b exp 0", overflow); end
            end
        end
        n_chk++; if (fill_level !== 3'd4) begin n_fail++; $display("FAIL ovf_fill: got %0d exp 4", fill_level); end
        n_chk++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b exp 1", overflow); end
        n_chk++; if (beat_cnt !== 2'd0) begin n_fail++; $display("FAIL ovf_beat: got %0d exp 0", beat_cnt); end
        for (int i = 0; i < 5; i++) step(1'b0, 32'd0, 64'd0, 1'b1);
        n_chk++; if (got.size() != 4) begin n_fail++; $display("FAIL ovf_count: got %0d exp 4", got.size()); end
        for (int i = 0; i < 4 && i < got.size(); i++) begin
            n_chk++; if (got[i] !== el[i]) begin n_fail++; $display("FAIL ovf_order[%0d]: got %h exp %h", i, got[i], el[i]); end
        end
        n_chk++; if (fill_level !== 3'd0 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL ovf_empty: got fill %0d valid %b exp 0 0", fill_level, out_valid);
        end
    endtask

    task automatic test_ovf_clear();
        logic [DATA_W-1:0] e0, e1;
        e0 = {rnd64(), rnd64()};
        e1 = {rnd64(), rnd64()};
        push_elem(e0, 1'b0);
        push_elem(e1, 1'b0);
        step(1'b1, 32'd9, 64'h2, 1'b0);
        n_chk++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovfclr_flag: got %b exp 0", overflow); end
        n_chk++; if (fill_level !== 3'd2) begin n_fail++; $display("FAIL ovfclr_fill: got %0d exp 2", fill_level); end
        n_chk++; if (out_data !== e0) begin n_fail++; $display("FAIL ovfclr_head: got %h exp %h", out_data, e0); end
        step(1'b1, 32'd10, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        n_chk++; if (fill_level !== 3'd2 || beat_cnt !== 2'd0 || overflow !== 1'b0 || out_data !== e0) begin
            n_fail++; $display("FAIL ignored_addr: got fill %0d beat %0d ovf %b head %h", fill_level, beat_cnt, overflow, out_data);
        end
        got.delete();
        step(1'b0, 32'd0, 64'd0, 1'b1);
        step(1'b0, 32'd0, 64'd0, 1'b1);
        n_chk++; if (got.size() != 2 || got[0] !== e0 || got[1] !== e1) begin
            n_fail++; $display("FAIL ovfclr_drain: got %0d elements exp 2 in order", got.size());
        end
    endtask

    task automatic test_full_pop();
        logic [DATA_W-1:0] el[5];
        for (int i = 0; i < 5; i++) el[i] = {rnd64(), rnd64()};
        for (int i = 0; i < 4; i++) push_elem(el[i], 1'b0);
        got.delete();
        step(1'b1, 32'd8, el[4][63:0], 1'b0);
        step(1'b1, 32'd8, el[4][127:64], 1'b1);
        n_chk++; if (fill_level !== 3'd4) begin n_fail++; $display("FAIL fullpop_fill: got %0d exp 4", fill_level); end
        n_chk++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL fullpop_ovf: got %b exp 0", overflow); end
        for (int i = 0; i < 5; i++) step(1'b0, 32'd0, 64'd0, 1'b1);
        n_chk++; if (got.size() != 5) begin n_fail++; $display("FAIL fullpop_count: got %0d exp 5", got.size()); end
        for (int i = 0; i < 5 && i < got.size(); i++) begin
            n_chk++; if (got[i] !== el[i]) begin n_fail++; $display("FAIL fullpop_order[%0d]: got %h exp %h", i, got[i], el[i]); end
        end
    endtask

    task automatic test_soft_clear();
        logic [CONF_W-1:0] a, b;
        push_elem({rnd64(), rnd64()}, 1'b0);
        push_elem({rnd64(), rnd64()}, 1'b0);
        step(1'b1, 32'd8, rnd64(), 1'b0);
        step(1'b1, 32'd9, 64'h1, 1'b0);
        n_chk++; if (beat_cnt !== 2'd0) begin n_fail++; $display("FAIL clr_beat: got %0d exp 0", beat_cnt); end
        n_chk++; if (fill_level !== 3'd0) begin n_fail++; $display("FAIL clr_fill: got %0d exp 0", fill_level); end
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL clr_valid: got %b exp 0", out_valid); end
        a = rnd64();
        b = rnd64();
        step(1'b1, 32'd8, a, 1'b0);
        step(1'b1, 32'd8, b, 1'b0);
        n_chk++; if (fill_level !== 3'd1 || out_data !== {b, a}) begin
            n_fail++; $display("FAIL clr_fresh: got fill %0d data %h exp 1 %h", fill_level, out_data, {b, a});
        end
        step(1'b0, 32'd0, 64'd0, 1'b1);
    endtask

    task automatic test_async_reset();
        logic [CONF_W-1:0] a, b;
        for (int i = 0; i < 3; i++) push_elem({rnd64(), rnd64()}, 1'b0);
        step(1'b1, 32'd8, rnd64(), 1'b0);
        n_chk++; if (fill_level !== 3'd3 || beat_cnt !== 2'd1) begin
            n_fail++; $display("FAIL arst_pre: got fill %0d beat %0d exp 3 1", fill_level, beat_cnt);
        end
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        n_chk++; if (fill_level !== 3'd0 || out_valid !== 1'b0 || overflow !== 1'b0 || beat_cnt !== 2'd0) begin
            n_fail++; $display("FAIL arst_now: got fill %0d valid %b ovf %b beat %0d exp 0", fill_level, out_valid, overflow, beat_cnt);
        end
        @(negedge clk);
        rst = 1'b0;
        a = rnd64();
        b = rnd64();
        step(1'b1, 32'd8, a, 1'b0);
        step(1'b1, 32'd8, b, 1'b0);
        n_chk++; if (fill_level !== 3'd1 || out_data !== {b, a}) begin
            n_fail++; $display("FAIL arst_after: got fill %0d data %h exp 1 %h", fill_level, out_data, {b, a});
        end
        step(1'b0, 32'd0, 64'd0, 1'b1);
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [CONF_W-1:0] d;
        int sel;
        got.delete();
        exp_pop.delete();
        for (int i = 0; i < 400; i++) begin
            sel = $urandom_range(0, 9);
            a = (sel < 6) ? 32'd8 : (sel == 6) ? 32'd9 : (sel == 7) ? 32'd10 : $urandom;
            d = rnd64();
            if (a == 32'd9 && $urandom_range(0, 3) != 0) d[0] = 1'b0;
            step($urandom_range(0, 3) != 0, a, d, $urandom_range(0, 2) == 0);
            n_chk++; if (fill_level !== 3'(mq.size())) begin n_fail++; $display("FAIL rnd_fill@%0d: got %0d exp %0d", i, fill_level, mq.size()); end
            n_chk++; if (out_valid !== (mq.size() != 0)) begin n_fail++; $display("FAIL rnd_valid@%0d: got %b exp %b", i, out_valid, mq.size() != 0); end
            n_chk++; if (beat_cnt !== 2'(part.size())) begin n_fail++; $display("FAIL rnd_beat@%0d: got %0d exp %0d", i, beat_cnt, part.size()); end
            n_chk++; if (overflow !== movf) begin n_fail++; $display("FAIL rnd_ovf@%0d: got %b exp %b", i, overflow, movf); end
            if (mq.size() != 0) begin
                n_chk++; if (out_data !== mq[0]) begin n_fail++; $display("FAIL rnd_head@%0d: got %h exp %h", i, out_data, mq[0]); end
            end
        end
        n_chk++; if (got.size() != exp_pop.size()) begin n_fail++; $display("FAIL rnd_popcount: got %0d exp %0d", got.size(), exp_pop.size()); end
        for (int i = 0; i < got.size() && i < exp_pop.size(); i++) begin
            n_chk++; if (got[i] !== exp_pop[i]) begin n_fail++; $display("FAIL rnd_pop[%0d]: got %h exp %h", i, got[i], exp_pop[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_assembly();
        test_overflow();
        test_ovf_clear();
        test_full_pop();
        test_soft_clear();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/config_write_fifo_wide.md
Name: config_write_fifo_wide

Overview:
Config-bus sink that gathers one or more config-word writes into a wide element and queues it for a downstream ready/valid stream. It generalises the single-word config write FIFO with:
- multi-beat assembly when the data width exceeds the config width;
- backpressure-aware overflow detection;
- a control register for soft clear;
- status outputs for register readback.

It sits between the config decoder and a datapath consumer.

Parameters:
ADDR, 0, config address of the data register; ADDR+1 is the control register
CONF_W, 64, config data width
DATA_W, 128, element width; BEATS = ceil(DATA_W/CONF_W)
DEPTH, 16, FIFO capacity in elements, >=2

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
conf_valid  in  1  config write strobe, single cycle, no backpressure
conf_addr  in  32  config write address
conf_data  in  CONF_W  config write data
out_data  out  DATA_W  head element
out_valid  out  1  head element valid
out_ready  in  1  consumer accepts
fill_level  out  $clog2(DEPTH+1)  stored elements
overflow  out  1  sticky: an element was dropped
beat_cnt  out  $clog2(BEATS+1)  beats held in the partial assembly

Behaviour:
Reset (async assert, sync release):
- out_valid=0, fill_level=0, overflow=0, beat_cnt=0, assembly register=0, read/write pointers=0.
- Applies immediately on assertion, including mid-assembly.

Data writes (conf_valid && conf_addr==ADDR):
- The beat is stored in lane beat_cnt, little-endian: lane k = bits [k*CONF_W +: CONF_W].
- If beat_cnt<BEATS-1: beat_cnt increments.
- Otherwise (final beat): the element is formed from the held lanes plus this beat, beat_cnt returns to 0, and a push is attempted the same cycle.
- Final-lane bits beyond DATA_W are discarded.
- BEATS==1: every write is a final beat.

Push acceptance:
- A push is accepted iff fill_level<DEPTH, or a pop occurs in the same cycle (out_valid && out_ready).
- If rejected: the element is dropped, overflow is set to 1, and beat_cnt still returns to 0.

Pop and output timing:
- Pop on out_valid && out_ready; the head advances.
- out_valid = (fill_level != 0).
- out_data is the head entry and is stable while out_valid && !out_ready.
- Latency: a final beat accepted at edge N gives out_valid=1 from edge N (visible the cycle after the write) when the FIFO was empty.
- Ordering is strict FIFO.

fill_level:
- +1 on an accepted push, -1 on a pop, unchanged on a simultaneous push and pop.
- Pointers wrap modulo DEPTH; DEPTH need not be a power of two.

Control writes (conf_valid && conf_addr==ADDR+1):
- bit0=1 (soft clear): empties the FIFO (fill_level=0, pointers reset), discards the partial assembly (beat_cnt=0), and drops out_valid the following cycle. A pop handshaken in that same cycle is still considered consumed.
- bit1=1: clears overflow.
- Both bits may be set in the same write.
- Other bits are ignored.

Other addresses:
- Writes to any other address have no effect.
- Only one config write can occur per cycle, so data and control writes never coincide.

No combinational path from conf_* to out_* outputs; all outputs are registered or derived from registered state.

Test Plan:
Configuration for all scenarios: CONF_W=64, DATA_W=128, DEPTH=4, ADDR=8, out_ready=1 unless stated.

1. Assembly: write addr 8 data 0x1111, then addr 8 data 0x2222 -> out_data=0x0000000000002222_0000000000001111 and out_valid=1 the cycle after the 2nd write; beat_cnt goes 1 then 0.
2. Overflow: out_ready=0, push 5 elements E1..E5 -> fill_level=4, overflow=1 after E5. Then out_ready=1 -> E1..E4 drained in order, fill_level=0, out_valid=0.
3. Full with simultaneous pop: fill_level=4, final beat of E5 in the same cycle as a pop of E1 -> E5 accepted, fill_level stays 4, overflow stays 0, later output order is E2..E5.
4. Soft clear: one beat to addr 8, 2 elements queued, write addr 9 data 0x1 -> beat_cnt=0, fill_level=0, out_valid=0. The next two beats form a fresh element from lane 0.
5. Overflow clear and ignored address: with overflow=1, write addr 9 data 0x2 -> overflow=0, FIFO contents untouched. A write to addr 10 changes nothing.
6. Reset: assert rst asynchronously with beat_cnt=1 and fill_level=3 -> all outputs 0 before the next clk edge. After release, two beats produce one correctly assembled element.
